// File: rtl/wavelet_pkg.sv
// Shared constants for the Sym4 reconstruction datapath: filter taps, detail modes
// and the final round/saturate helper.
package wavelet_pkg;

    localparam int COEF_WIDTH_DEF = 25;
    localparam int COEF_FRAC_DEF  = 23;

    // Sym4 reconstruction lowpass taps in Q1.23
    localparam int SYM4_REC_H0 = 270307;
    localparam int SYM4_REC_H1 = -105730;
    localparam int SYM4_REC_H2 = -832314;
    localparam int SYM4_REC_H3 = 2498612;
    localparam int SYM4_REC_H4 = 6742249;
    localparam int SYM4_REC_H5 = 4174328;
    localparam int SYM4_REC_H6 = -248601;
    localparam int SYM4_REC_H7 = -635569;

    typedef enum logic [1:0] {
        MODE_APPROX = 2'd0,
        MODE_FULL   = 2'd1,
        MODE_HARD   = 2'd2,
        MODE_SOFT   = 2'd3
    } mode_t;

    localparam int ACC_MAX = 128;

    typedef struct packed {
        logic signed [ACC_MAX-1:0] value;
        logic                      sat;
    } round_sat_t;

    // Round half-up, drop frac bits, clamp into a dw-bit signed range.
    function automatic round_sat_t round_sat(input logic signed [ACC_MAX-1:0] acc,
                                             input int frac, input int dw);
        logic signed [ACC_MAX-1:0] one;
        logic signed [ACC_MAX-1:0] shifted;
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        round_sat_t                res;
        one     = {{(ACC_MAX-1){1'b0}}, 1'b1};
        shifted = (acc + (one <<< (frac - 1))) >>> frac;
        hi      = (one <<< (dw - 1)) - one;
        lo      = -(one <<< (dw - 1));
        res.sat = 1'b1;
        if (shifted > hi) begin
            res.value = hi;
        end else if (shifted < lo) begin
            res.value = lo;
        end else begin
            res.value = shifted;
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/wavelet_poly_mac4.sv
// Four-tap pipelined dot product: registered products, then a registered
// pairwise-summed total with three guard bits.
module wavelet_poly_mac4
    import wavelet_pkg::*;
#(
    parameter int XW = 48,
    parameter int CW = 25
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [XW-1:0]    x    [4],
    input  logic signed [CW-1:0]    coef [4],
    output logic signed [XW+CW+2:0] sum
);

    localparam int PW = XW + CW;
    localparam int SW = PW + 3;

    logic signed [PW-1:0] prod [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) prod[j] <= '0;
            sum <= '0;
        end else begin
            for (int j = 0; j < 4; j++) prod[j] <= PW'(x[j]) * PW'(coef[j]);
            sum <= (SW'(prod[0]) + SW'(prod[1])) + (SW'(prod[2]) + SW'(prod[3]));
        end
    end

endmodule

// File: rtl/wavelet_rec_level.sv
// One Sym4 synthesis level: merges approximation and (optionally thresholded)
// detail samples into the even/odd reconstructed samples of the finer level.
module wavelet_rec_level
    import wavelet_pkg::*;
#(
    parameter int INTERNAL_WIDTH = 48,
    parameter int DOUT_WIDTH     = 48,
    parameter int COEF_WIDTH     = COEF_WIDTH_DEF,
    parameter int COEF_FRAC      = COEF_FRAC_DEF,
    parameter int REC_H0         = SYM4_REC_H0,
    parameter int REC_H1         = SYM4_REC_H1,
    parameter int REC_H2         = SYM4_REC_H2,
    parameter int REC_H3         = SYM4_REC_H3,
    parameter int REC_H4         = SYM4_REC_H4,
    parameter int REC_H5         = SYM4_REC_H5,
    parameter int REC_H6         = SYM4_REC_H6,
    parameter int REC_H7         = SYM4_REC_H7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic [1:0]                       mode,
    input  logic [INTERNAL_WIDTH-1:0]        thresh,
    input  logic                             din_valid,
    input  logic signed [INTERNAL_WIDTH-1:0] a_in,
    input  logic signed [INTERNAL_WIDTH-1:0] d_in,
    output logic                             dout_valid,
    output logic signed [DOUT_WIDTH-1:0]     r_even,
    output logic signed [DOUT_WIDTH-1:0]     r_odd,
    output logic                             sat_flag
);

    localparam int IW = INTERNAL_WIDTH;
    localparam int SW = IW + COEF_WIDTH + 3;
    localparam int H [8] = '{REC_H0, REC_H1, REC_H2, REC_H3, REC_H4, REC_H5, REC_H6, REC_H7};

    logic signed [IW-1:0] hist_a [3];
    logic signed [IW-1:0] hist_d [3];
    logic signed [IW-1:0] win_a  [4];
    logic signed [IW-1:0] win_d  [4];
    logic signed [IW:0]   d_ext;
    logic        [IW:0]   d_abs;
    logic        [IW:0]   th_ext;
    logic signed [IW-1:0] d_soft;
    logic signed [IW-1:0] d_pre;
    logic                 d_small;

    always_comb begin
        d_ext   = {d_in[IW-1], d_in};
        d_abs   = d_ext[IW] ? unsigned'(-d_ext) : unsigned'(d_ext);
        th_ext  = {1'b0, thresh};
        d_small = (d_abs <= th_ext);
        d_soft  = d_ext[IW] ? IW'(d_ext + signed'(th_ext)) : IW'(d_ext - signed'(th_ext));
        d_pre   = '0;
        case (mode)
            MODE_FULL: d_pre = d_in;
            MODE_HARD: d_pre = d_small ? '0 : d_in;
            MODE_SOFT: d_pre = d_small ? '0 : d_soft;
            default:   d_pre = '0;
        endcase
    end

    // Tap 0 is the incoming sample, so the products see it on the accept edge itself.
    always_comb begin
        win_a[0] = a_in;
        win_d[0] = d_pre;
        for (int j = 1; j < 4; j++) begin
            win_a[j] = hist_a[j-1];
            win_d[j] = hist_d[j-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 3; j++) begin
                hist_a[j] <= '0;
                hist_d[j] <= '0;
            end
        end else if (clr) begin
            for (int j = 0; j < 3; j++) begin
                hist_a[j] <= '0;
                hist_d[j] <= '0;
            end
        end else if (din_valid) begin
            for (int j = 0; j < 3; j++) begin
                hist_a[j] <= win_a[j];
                hist_d[j] <= win_d[j];
            end
        end
    end

    logic signed [COEF_WIDTH-1:0] h_even [4];
    logic signed [COEF_WIDTH-1:0] h_odd  [4];
    logic signed [COEF_WIDTH-1:0] g_even [4];
    logic signed [COEF_WIDTH-1:0] g_odd  [4];

    // Highpass taps: G[k] = (-1)^k * H[7-k]
    for (genvar j = 0; j < 4; j++) begin : g_coef
        assign h_even[j] = COEF_WIDTH'(H[2*j]);
        assign h_odd[j]  = COEF_WIDTH'(H[2*j+1]);
        assign g_even[j] = COEF_WIDTH'(H[7-2*j]);
        assign g_odd[j]  = COEF_WIDTH'(-H[6-2*j]);
    end

    logic signed [SW-1:0] sum_he, sum_ho, sum_ge, sum_go;

    wavelet_poly_mac4 #(.XW(IW), .CW(COEF_WIDTH)) u_mac_he (
        .clk(clk), .rst_n(rst_n), .x(win_a), .coef(h_even), .sum(sum_he));
    wavelet_poly_mac4 #(.XW(IW), .CW(COEF_WIDTH)) u_mac_ho (
        .clk(clk), .rst_n(rst_n), .x(win_a), .coef(h_odd), .sum(sum_ho));
    wavelet_poly_mac4 #(.XW(IW), .CW(COEF_WIDTH)) u_mac_ge (
        .clk(clk), .rst_n(rst_n), .x(win_d), .coef(g_even), .sum(sum_ge));
    wavelet_poly_mac4 #(.XW(IW), .CW(COEF_WIDTH)) u_mac_go (
        .clk(clk), .rst_n(rst_n), .x(win_d), .coef(g_odd), .sum(sum_go));

    logic signed [SW+1:0] acc_even, acc_odd;
    round_sat_t           rs_even, rs_odd;
    logic [1:0]           valid_pipe;

    always_comb begin
        acc_even = (SW+2)'(sum_he) + (SW+2)'(sum_ge);
        acc_odd  = (SW+2)'(sum_ho) + (SW+2)'(sum_go);
        rs_even  = round_sat(ACC_MAX'(acc_even), COEF_FRAC, DOUT_WIDTH);
        rs_odd   = round_sat(ACC_MAX'(acc_odd), COEF_FRAC, DOUT_WIDTH);
    end

    // A flush kills in-flight valids but leaves the last delivered pair on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe <= '0;
            dout_valid <= 1'b0;
            r_even     <= '0;
            r_odd      <= '0;
            sat_flag   <= 1'b0;
        end else if (clr) begin
            valid_pipe <= '0;
            dout_valid <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            valid_pipe <= {valid_pipe[0], din_valid};
            dout_valid <= valid_pipe[1];
            if (valid_pipe[1]) begin
                r_even <= DOUT_WIDTH'(rs_even.value);
                r_odd  <= DOUT_WIDTH'(rs_odd.value);
                if (rs_even.sat || rs_odd.sat) sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wavelet_rec_level.sv
// Directed bench for wavelet_rec_level: a full-width instance and a 16-bit output
// instance share the same stimulus.
module tb_wavelet_rec_level;

    localparam int IW = 48;
    localparam longint H [8] = '{270307, -105730, -832314, 2498612,
                                 6742249, 4174328, -248601, -635569};

    logic                 clk = 1'b0;
    logic                 rst_n, clr, din_valid;
    logic [1:0]           mode;
    logic [IW-1:0]        thresh;
    logic signed [IW-1:0] a_in, d_in;
    logic                 dout_valid, sat_flag;
    logic signed [IW-1:0] r_even, r_odd;
    logic                 n_dout_valid, n_sat_flag;
    logic signed [15:0]   n_r_even, n_r_odd;

    always #5 clk = ~clk;

    wavelet_rec_level #(.INTERNAL_WIDTH(IW), .DOUT_WIDTH(IW)) dut_wide (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .thresh(thresh),
        .din_valid(din_valid), .a_in(a_in), .d_in(d_in), .dout_valid(dout_valid),
        .r_even(r_even), .r_odd(r_odd), .sat_flag(sat_flag));

    wavelet_rec_level #(.INTERNAL_WIDTH(IW), .DOUT_WIDTH(16)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .thresh(thresh),
        .din_valid(din_valid), .a_in(a_in), .d_in(d_in), .dout_valid(n_dout_valid),
        .r_even(n_r_even), .r_odd(n_r_odd), .sat_flag(n_sat_flag));

    typedef struct {
        longint even;
        longint odd;
        int     at;
    } sample_t;

    sample_t outq [$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin : monitor
        sample_t s;
        #1;
        if (dout_valid === 1'b1) begin
            s.even = longint'(r_even);
            s.odd  = longint'(r_odd);
            s.at   = cyc;
            outq.push_back(s);
        end
    end

    function automatic longint gcoef(input int k);
        return (k % 2 == 0) ? H[7-k] : -H[7-k];
    endfunction

    function automatic longint rnd(input longint p);
        return (p + (64'sd1 <<< 22)) >>> 23;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic c, input longint a, input longint d);
        din_valid = v;
        clr       = c;
        a_in      = IW'(a);
        d_in      = IW'(d);
        tick();
        din_valid = 1'b0;
        clr       = 1'b0;
    endtask

    // One nonzero sample followed by three zeros walks the value through every tap.
    task automatic runImpulse(input string tag, input logic [1:0] m, input longint th,
                              input longint a, input longint d, input longint dexp);
        sample_t s;
        int      start;
        mode   = m;
        thresh = IW'(th);
        outq.delete();
        applyStimulus(1'b1, 1'b0, a, d);
        start = cyc;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0, 0);
        repeat (4) tick();
        checkOutput({tag, " count"}, outq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < outq.size()) s = outq[k];
            else begin
                s.even = 0;
                s.odd  = 0;
                s.at   = 0;
            end
            if (k == 0) checkOutput({tag, " latency"}, s.at, start + 2);
            checkOutput($sformatf("%s even%0d", tag, k), s.even, rnd(H[2*k] * a + gcoef(2*k) * dexp));
            checkOutput($sformatf("%s odd%0d", tag, k), s.odd, rnd(H[2*k+1] * a + gcoef(2*k+1) * dexp));
        end
    endtask

    initial begin
        longint sum_e, sum_o;
        rst_n = 1'b0; clr = 1'b0; din_valid = 1'b0; mode = 2'd0;
        thresh = '0; a_in = '0; d_in = '0;
        repeat (2) tick();
        checkOutput("reset dout_valid", dout_valid, 0);
        checkOutput("reset r_even", r_even, 0);
        checkOutput("reset r_odd", r_odd, 0);
        checkOutput("reset sat_flag", sat_flag, 0);
        checkOutput("reset narrow r_even", n_r_even, 0);
        rst_n = 1'b1;
        tick();

        runImpulse("approx impulse", 2'd1, 0, 64'sd8388608, 0, 0);
        runImpulse("detail impulse", 2'd1, 0, 0, 64'sd8388608, 64'sd8388608);
        runImpulse("mode0 detail", 2'd0, 0, 0, 64'sd8388608, 0);
        runImpulse("hard below", 2'd2, 100, 0, 50, 0);
        runImpulse("hard above", 2'd2, 100, 0, -150, -150);
        runImpulse("hard equal", 2'd2, 100, 0, -100, 0);
        runImpulse("soft below", 2'd3, 100, 0, 50, 0);
        runImpulse("soft neg", 2'd3, 100, 0, -150, -50);
        runImpulse("soft pos", 2'd3, 100, 0, 150, 50);

        sum_e = H[0] + H[2] + H[4] + H[6];
        sum_o = H[1] + H[3] + H[5] + H[7];
        applyStimulus(1'b0, 1'b1, 0, 0);
        checkOutput("pre-sat narrow sat_flag", n_sat_flag, 0);
        mode = 2'd0;
        repeat (8) applyStimulus(1'b1, 1'b0, 100000, 0);
        checkOutput("sat pos r_even", n_r_even, 32767);
        checkOutput("sat pos r_odd", n_r_odd, 32767);
        checkOutput("sat pos flag", n_sat_flag, 1);
        checkOutput("wide pos r_even", r_even, rnd(100000 * sum_e));
        checkOutput("wide pos r_odd", r_odd, rnd(100000 * sum_o));
        repeat (8) applyStimulus(1'b1, 1'b0, -100000, 0);
        checkOutput("sat neg r_even", n_r_even, -32768);
        checkOutput("sat neg r_odd", n_r_odd, -32768);
        checkOutput("wide neg r_even", r_even, rnd(-100000 * sum_e));
        checkOutput("wide sat_flag", sat_flag, 0);
        repeat (3) tick();
        checkOutput("sat sticky", n_sat_flag, 1);
        applyStimulus(1'b0, 1'b1, 0, 0);
        checkOutput("clr sat_flag", n_sat_flag, 0);
        checkOutput("clr holds r_even", n_r_even, -32768);

        mode = 2'd1;
        outq.delete();
        applyStimulus(1'b1, 1'b0, 5000000, -3000000);
        applyStimulus(1'b1, 1'b0, 777, 999);
        applyStimulus(1'b1, 1'b1, 64'sd8388608, 0);
        repeat (3) tick();
        checkOutput("flush no output", outq.size(), 0);
        checkOutput("flush narrow sat_flag", n_sat_flag, 0);
        runImpulse("post-flush impulse", 2'd1, 0, 64'sd8388608, 0, 0);
        checkOutput("post-flush sat_flag", sat_flag, 0);

        outq.delete();
        applyStimulus(1'b1, 1'b0, 64'sd8388608, 0);
        applyStimulus(1'b1, 1'b0, 64'sd8388608, 0);
        rst_n = 1'b0;
        #2;
        checkOutput("midreset r_even", r_even, 0);
        checkOutput("midreset dout_valid", dout_valid, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        checkOutput("midreset no output", outq.size(), 0);
        checkOutput("midreset r_odd", r_odd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
